// File: rtl/ireg_pkg.sv
// Shared helpers for the skewed border input buffer: per-channel depth and
// total stage count of the skew pipeline.
package ireg_pkg;

    function automatic int skew_depth(input int c, input int step);
        return 1 + c * step;
    endfunction

    function automatic int total_stages(input int ch, input int step);
        int sum;
        sum = 0;
        for (int c = 0; c < ch; c++) begin
            sum += skew_depth(c, step);
        end
        return sum;
    endfunction

endpackage

// File: rtl/ireg_delay_line.sv
// Single-channel shift line carrying a valid bit with each datum; exposes the
// last stage plus an occupancy summary of all stages.
module ireg_delay_line
    import ireg_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    d_valid,
    input  logic signed [WIDTH-1:0] d_data,
    output logic                    q_valid,
    output logic signed [WIDTH-1:0] q_data,
    output logic                    any_valid,
    output logic [15:0]             valid_count
);

    logic signed [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]        valid_q;

    // Bubbles enter as zero data so an invalid slot never leaks stale operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else if (clr) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else if (en) begin
            valid_q[0] <= d_valid;
            data_q[0]  <= d_valid ? d_data : '0;
            for (int k = 1; k < DEPTH; k++) begin
                valid_q[k] <= valid_q[k-1];
                data_q[k]  <= data_q[k-1];
            end
        end
    end

    assign q_valid     = valid_q[DEPTH-1];
    assign q_data      = data_q[DEPTH-1];
    assign any_valid   = |valid_q;
    assign valid_count = 16'($countones(valid_q));

endmodule

// File: rtl/ireg_skew_border.sv
// Border input buffer for the systolic array edge: channel c is delayed by
// 1 + c*SKEW_STEP enabled cycles to form the diagonal operand wavefront.
module ireg_skew_border
    import ireg_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CH        = 4,
    parameter int SKEW_STEP = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [CH-1:0]         i_valid,
    input  logic [CH*WIDTH-1:0]   i_data,
    output logic [CH-1:0]         o_valid,
    output logic [CH*WIDTH-1:0]   o_data,
    output logic                  o_busy
);

    localparam int TOTAL_STAGES = total_stages(CH, SKEW_STEP);

    logic [CH-1:0] lane_busy;
    logic [15:0]   lane_count [CH];
    logic [15:0]   stage_count;

    for (genvar c = 0; c < CH; c++) begin : g_lane
        localparam int DEPTH = skew_depth(c, SKEW_STEP);
        logic signed [WIDTH-1:0] lane_q;

        ireg_delay_line #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_line (
            .clk         (clk),
            .rst         (rst),
            .en          (en),
            .clr         (clr),
            .d_valid     (i_valid[c]),
            .d_data      (i_data[c*WIDTH +: WIDTH]),
            .q_valid     (o_valid[c]),
            .q_data      (lane_q),
            .any_valid   (lane_busy[c]),
            .valid_count (lane_count[c])
        );

        assign o_data[c*WIDTH +: WIDTH] = lane_q;
    end

    assign o_busy = |lane_busy;

    always_comb begin
        stage_count = '0;
        for (int k = 0; k < CH; k++) begin
            stage_count = stage_count + lane_count[k];
        end
    end

    // Occupancy can never exceed the pipeline size, and busy means occupied.
    assert property (@(posedge clk) disable iff (rst) int'(stage_count) <= TOTAL_STAGES);
    assert property (@(posedge clk) disable iff (rst) (stage_count != '0) == o_busy);

endmodule

// File: tb/tb_ireg_skew_border.sv
// Directed bench for ireg_skew_border: a skewed (step 1) and an unskewed
// (step 0) instance share stimulus and are checked against a history model.
module tb_ireg_skew_border;

    localparam int W  = 16;
    localparam int CH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            clr;
    logic [CH-1:0]   i_valid;
    logic [CH*W-1:0] i_data;

    logic [CH-1:0]   o_valid1, o_valid0;
    logic [CH*W-1:0] o_data1, o_data0;
    logic            o_busy1, o_busy0;

    int errors = 0;
    int checks = 0;
    bit compare_on = 1'b0;

    // Accepted slots since the last clear/reset, oldest first.
    logic [CH-1:0]   hv [$];
    logic [CH*W-1:0] hd [$];

    always #5 clk = ~clk;

    ireg_skew_border #(.WIDTH(W), .CH(CH), .SKEW_STEP(1)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .i_valid(i_valid), .i_data(i_data),
        .o_valid(o_valid1), .o_data(o_data1), .o_busy(o_busy1)
    );

    ireg_skew_border #(.WIDTH(W), .CH(CH), .SKEW_STEP(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .i_valid(i_valid), .i_data(i_data),
        .o_valid(o_valid0), .o_data(o_data0), .o_busy(o_busy0)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge take them, return 1 time unit later.
    task automatic applyStimulus(input logic e, input logic c, input logic [CH-1:0] v, input logic [CH*W-1:0] d);
        en      = e;
        clr     = c;
        i_valid = v;
        i_data  = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CH*W-1:0] pack4(input logic [W-1:0] d3, input logic [W-1:0] d2,
                                              input logic [W-1:0] d1, input logic [W-1:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    // What the outputs must be: channel c shows the slot accepted D(c)-1 enabled edges ago.
    function automatic void model_out(input int step, output logic [CH-1:0] ev,
                                      output logic [CH*W-1:0] ed, output logic eb);
        int n;
        int d;
        logic [CH-1:0]   v;
        logic [CH*W-1:0] dd;
        n  = hv.size();
        ev = '0;
        ed = '0;
        eb = 1'b0;
        for (int c = 0; c < CH; c++) begin
            d = 1 + c * step;
            if (n >= d) begin
                v  = hv[n-d];
                dd = hd[n-d];
                ev[c] = v[c];
                ed[c*W +: W] = dd[c*W +: W];
            end
            for (int j = n - d; j < n; j++) begin
                if (j >= 0) begin
                    v = hv[j];
                    if (v[c]) eb = 1'b1;
                end
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [CH*W-1:0] acc;
        if (rst || clr) begin
            hv.delete();
            hd.delete();
        end else if (en) begin
            acc = '0;
            for (int c = 0; c < CH; c++) begin
                if (i_valid[c]) acc[c*W +: W] = i_data[c*W +: W];
            end
            hv.push_back(i_valid);
            hd.push_back(acc);
            if (hv.size() > 8) begin
                void'(hv.pop_front());
                void'(hd.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        logic [CH-1:0]   ev;
        logic [CH*W-1:0] ed;
        logic            eb;
        if (compare_on) begin
            model_out(1, ev, ed, eb);
            checkOutput("cyc_valid_s1", 64'(o_valid1), 64'(ev));
            checkOutput("cyc_data_s1", o_data1, ed);
            checkOutput("cyc_busy_s1", 64'(o_busy1), 64'(eb));
            model_out(0, ev, ed, eb);
            checkOutput("cyc_valid_s0", 64'(o_valid0), 64'(ev));
            checkOutput("cyc_data_s0", o_data0, ed);
            checkOutput("cyc_busy_s0", 64'(o_busy0), 64'(eb));
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; i_valid = '0; i_data = '0;
        @(posedge clk);
        #1;
        checkOutput("reset_valid", 64'(o_valid1), 64'h0);
        checkOutput("reset_data", o_data1, 64'h0);
        checkOutput("reset_busy", 64'(o_busy1), 64'h0);
        compare_on = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, '0, '0);

        $display("[TB] wavefront");
        applyStimulus(1'b1, 1'b0, 4'hF, pack4(16'h0044, 16'h0033, 16'h0022, 16'h0011));
        checkOutput("wave_v0", 64'(o_valid1), 64'h1);
        checkOutput("wave_d0", 64'(o_data1[15:0]), 64'h0011);
        checkOutput("skew0_all", 64'(o_valid0), 64'hF);
        checkOutput("skew0_data", o_data0, 64'h0044_0033_0022_0011);
        applyStimulus(1'b1, 1'b0, '0, '0);
        checkOutput("wave_v1", 64'(o_valid1), 64'h2);
        checkOutput("wave_d1", 64'(o_data1[31:16]), 64'h0022);
        applyStimulus(1'b1, 1'b0, '0, '0);
        checkOutput("wave_v2", 64'(o_valid1), 64'h4);
        applyStimulus(1'b1, 1'b0, '0, '0);
        checkOutput("wave_v3", 64'(o_valid1), 64'h8);
        checkOutput("wave_d3", 64'(o_data1[63:48]), 64'h0044);
        checkOutput("wave_busy_last", 64'(o_busy1), 64'h1);
        applyStimulus(1'b1, 1'b0, '0, '0);
        checkOutput("wave_busy_fall", 64'(o_busy1), 64'h0);

        $display("[TB] stall");
        applyStimulus(1'b1, 1'b0, 4'hF, pack4(16'h0044, 16'h0033, 16'h0022, 16'h0011));
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1'b0, 1'b0, 4'hF, pack4(16'h0BAD, 16'h0BAD, 16'h0BAD, 16'h0BAD));
            checkOutput("stall_hold_v", 64'(o_valid1), 64'h1);
            checkOutput("stall_busy", 64'(o_busy1), 64'h1);
        end
        applyStimulus(1'b1, 1'b0, '0, '0);
        checkOutput("stall_v1", 64'(o_valid1), 64'h2);
        checkOutput("stall_d1", 64'(o_data1[31:16]), 64'h0022);
        repeat (3) applyStimulus(1'b1, 1'b0, '0, '0);

        $display("[TB] clear");
        applyStimulus(1'b1, 1'b0, 4'hF, pack4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF));
        checkOutput("clr_pre_v", 64'(o_valid1), 64'h1);
        checkOutput("clr_pre_d", 64'(o_data1[15:0]), 64'h7FFF);
        applyStimulus(1'b1, 1'b1, 4'hF, pack4(16'h1111, 16'h1111, 16'h1111, 16'h1111));
        checkOutput("clr_v", 64'(o_valid1), 64'h0);
        checkOutput("clr_d", o_data1, 64'h0);
        checkOutput("clr_busy", 64'(o_busy1), 64'h0);
        applyStimulus(1'b1, 1'b0, '0, '0);
        checkOutput("clr_drop", 64'(o_valid0), 64'h0);

        $display("[TB] async reset");
        applyStimulus(1'b1, 1'b0, 4'hF, pack4(16'h1234, 16'h1234, 16'h1234, 16'h1234));
        applyStimulus(1'b1, 1'b0, '0, '0);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("arst_v", 64'(o_valid1), 64'h0);
        checkOutput("arst_d", o_data1, 64'h0);
        checkOutput("arst_busy", 64'(o_busy1), 64'h0);
        checkOutput("arst_d_s0", o_data0, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 4'hF, pack4(16'h8000, 16'h8000, 16'h8000, 16'h8000));
        checkOutput("arst_neg0", 64'(o_data1[15:0]), 64'h8000);
        applyStimulus(1'b1, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, '0);
        checkOutput("arst_neg3_v", 64'(o_valid1), 64'h8);
        checkOutput("arst_neg3_d", 64'(o_data1[63:48]), 64'h8000);
        applyStimulus(1'b1, 1'b0, '0, '0);

        $display("[TB] bubbles");
        applyStimulus(1'b1, 1'b0, 4'h4, pack4(16'h0, 16'hFFFB, 16'h0, 16'h0));
        checkOutput("bub_s0_first", 64'(o_data0[47:32]), 64'hFFFB);
        applyStimulus(1'b1, 1'b0, 4'h0, pack4(16'h0, 16'h0009, 16'h0, 16'h0));
        checkOutput("bub_s0_gap_v", 64'(o_valid0), 64'h0);
        checkOutput("bub_s0_gap_d", o_data0, 64'h0);
        applyStimulus(1'b1, 1'b0, 4'h4, pack4(16'h0, 16'hFFF9, 16'h0, 16'h0));
        checkOutput("bub_a_v", 64'(o_valid1), 64'h4);
        checkOutput("bub_a_d", 64'(o_data1[47:32]), 64'hFFFB);
        applyStimulus(1'b1, 1'b0, '0, '0);
        checkOutput("bub_b_v", 64'(o_valid1), 64'h0);
        checkOutput("bub_b_d", o_data1, 64'h0);
        applyStimulus(1'b1, 1'b0, '0, '0);
        checkOutput("bub_c_v", 64'(o_valid1), 64'h4);
        checkOutput("bub_c_d", 64'(o_data1[47:32]), 64'hFFF9);
        repeat (4) applyStimulus(1'b1, 1'b0, '0, '0);

        compare_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
